// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Port 0 (single-cycle ALU) wins by default. Port 1 (long-latency unit) gains
// priority after MAX_WAIT consecutive held-off cycles. A pending-write
// scoreboard tracks the destinations of in-flight long-latency ops so that
// decode can stall on RAW/WAW hazards.
module regfile_wb_arbiter #(
   parameter int XLEN     = 32,
   parameter int REG_W    = 5,
   parameter int MAX_WAIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             p0_valid,
   output logic             p0_ready,
   input  logic [REG_W-1:0] p0_rd,
   input  logic [XLEN-1:0]  p0_data,
   input  logic             p1_valid,
   output logic             p1_ready,
   input  logic [REG_W-1:0] p1_rd,
   input  logic [XLEN-1:0]  p1_data,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [REG_W-1:0] issue_rd,
   input  logic [REG_W-1:0] q_rs1,
   input  logic [REG_W-1:0] q_rs2,
   input  logic [REG_W-1:0] q_rd,
   output logic             hazard,
   output logic             wr_en,
   output logic [REG_W-1:0] wr_rd,
   output logic [XLEN-1:0]  wr_data
);

   localparam int NREG  = 1 << REG_W;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] wait_cnt;
   logic             starve;
   logic             p0_acc;
   logic             p1_acc;
   logic             wr_src;
   logic [NREG-1:0]  pending;
   logic [NREG-1:0]  pending_nxt;

   // Arbitration, issue gating and hazard query are pure functions of current state.
   always_comb begin
      starve      = (wait_cnt == WAIT_MAX);
      p0_ready    = !(p1_valid && starve);
      p1_ready    = !p0_valid || starve;
      p0_acc      = p0_valid && p0_ready;
      p1_acc      = p1_valid && p1_ready;
      issue_ready = (issue_rd == '0) || !pending[issue_rd];
      hazard      = ((q_rs1 != '0) && pending[q_rs1]) ||
                    ((q_rs2 != '0) && pending[q_rs2]) ||
                    ((q_rd  != '0) && pending[q_rd]);
   end

   // Port 1 held off: count up to MAX_WAIT; any port 1 accept or idle cycle restarts.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wait_cnt <= '0;
      end else if (p1_valid && !p1_ready) begin
         if (wait_cnt != WAIT_MAX)
            wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   // Register the accepted write; rd==0 is consumed without raising wr_en.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_en   <= 1'b0;
         wr_rd   <= '0;
         wr_data <= '0;
         wr_src  <= 1'b0;
      end else if (p0_acc) begin
         wr_en   <= (p0_rd != '0);
         wr_rd   <= p0_rd;
         wr_data <= p0_data;
         wr_src  <= 1'b0;
      end else if (p1_acc) begin
         wr_en   <= (p1_rd != '0);
         wr_rd   <= p1_rd;
         wr_data <= p1_data;
         wr_src  <= 1'b1;
      end else begin
         wr_en   <= 1'b0;
      end
   end

   // Next scoreboard: clear on a port 1 register-file write, set on dispatch.
   always_comb begin
      pending_nxt = pending;
      if (wr_en && wr_src)
         pending_nxt[wr_rd] = 1'b0;
      if (issue_valid && issue_ready && (issue_rd != '0))
         pending_nxt[issue_rd] = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   // Scoreboard state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         pending <= '0;
      else
         pending <= pending_nxt;
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed stimulus pushes expected register-file
// writes into a queue; a negedge monitor pops and compares every wr_en pulse.
module tb_regfile_wb_arbiter;

   localparam int XLEN  = 32;
   localparam int REG_W = 5;

   typedef struct {
      logic [REG_W-1:0] rd;
      logic [XLEN-1:0]  data;
   } wr_t;

   logic             clk;
   logic             reset;
   logic             p0_valid, p0_ready;
   logic [REG_W-1:0] p0_rd;
   logic [XLEN-1:0]  p0_data;
   logic             p1_valid, p1_ready;
   logic [REG_W-1:0] p1_rd;
   logic [XLEN-1:0]  p1_data;
   logic             issue_valid, issue_ready;
   logic [REG_W-1:0] issue_rd;
   logic [REG_W-1:0] q_rs1, q_rs2, q_rd;
   logic             hazard;
   logic             wr_en;
   logic [REG_W-1:0] wr_rd;
   logic [XLEN-1:0]  wr_data;

   int  errors = 0;
   int  checks = 0;
   wr_t expq[$];
   logic [XLEN-1:0] rf [0:(1<<REG_W)-1];

   regfile_wb_arbiter #(.XLEN(XLEN), .REG_W(REG_W), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_rd(p0_rd), .p0_data(p0_data),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_rd(p1_rd), .p1_data(p1_data),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_rd(issue_rd),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .hazard(hazard),
      .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model fed by the write port.
   always @(posedge clk)
      if (wr_en) rf[wr_rd] <= wr_data;

   // Monitor: every write pulse must match the next expected write.
   always @(negedge clk) begin
      if (reset === 1'b1 && wr_en === 1'b1) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got rd=%0d data=%0h, required no write", wr_rd, wr_data);
         end else begin
            wr_t e;
            e = expq.pop_front();
            if (wr_rd !== e.rd || wr_data !== e.data) begin
               errors++;
               $display("FAIL write_order: got rd=%0d data=%0h, required rd=%0d data=%0h",
                        wr_rd, wr_data, e.rd, e.data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [REG_W-1:0] rd, input logic [XLEN-1:0] data);
      wr_t e;
      e.rd = rd;
      e.data = data;
      expq.push_back(e);
   endtask

   initial begin
      reset = 1'b0;
      p0_valid = 1'b1; p0_rd = 5; p0_data = 32'h5A;
      p1_valid = 1'b0; p1_rd = 0; p1_data = 0;
      issue_valid = 1'b0; issue_rd = 0;
      q_rs1 = 5; q_rs2 = 0; q_rd = 0;

      // Reset held with a pending request: no writes, scoreboard empty.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("reset_wr_en", 64'(wr_en), 64'd0);
      end
      chk("reset_wr_rd", 64'(wr_rd), 64'd0);
      chk("reset_wr_data", 64'(wr_data), 64'd0);
      chk("reset_hazard", 64'(hazard), 64'd0);

      // Release and accept a single port 0 write.
      reset = 1'b1; p0_data = 32'hA5;
      #1;
      chk("p0_ready_idle", 64'(p0_ready), 64'd1);
      expect_wr(5, 32'hA5);
      tick();
      p0_valid = 1'b0;
      chk("first_wr_en", 64'(wr_en), 64'd1);
      tick();

      // Starvation: port 0 wins four cycles, then port 1 takes priority.
      p0_valid = 1'b1; p0_rd = 3; p0_data = 32'h11;
      p1_valid = 1'b1; p1_rd = 4; p1_data = 32'h22;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("starve_p0_ready", 64'(p0_ready), 64'd1);
         chk("starve_p1_ready", 64'(p1_ready), 64'd0);
         expect_wr(3, 32'h11);
         tick();
      end
      #1;
      chk("starved_p1_ready", 64'(p1_ready), 64'd1);
      chk("starved_p0_ready", 64'(p0_ready), 64'd0);
      expect_wr(4, 32'h22);
      tick();
      // Counter restarted: port 0 wins again.
      chk("post_starve_p1_ready", 64'(p1_ready), 64'd0);
      chk("post_starve_p0_ready", 64'(p0_ready), 64'd1);
      expect_wr(3, 32'h11);
      tick();
      p0_valid = 1'b0; p1_valid = 1'b0;
      tick();

      // Long-latency issue to rd=7, then port 1 retires it.
      issue_valid = 1'b1; issue_rd = 7;
      #1;
      chk("issue_ready_free", 64'(issue_ready), 64'd1);
      tick();
      issue_valid = 1'b0; q_rs1 = 7;
      #1;
      chk("hazard_rs1_pending", 64'(hazard), 64'd1);
      chk("issue_ready_pending", 64'(issue_ready), 64'd0);
      p1_valid = 1'b1; p1_rd = 7; p1_data = 32'hDEAD;
      expect_wr(7, 32'hDEAD);
      tick();
      p1_valid = 1'b0;
      chk("wr_en_p1", 64'(wr_en), 64'd1);
      chk("hazard_during_wr", 64'(hazard), 64'd1);
      tick();
      chk("hazard_cleared", 64'(hazard), 64'd0);
      chk("rf_read_7", 64'(rf[7]), 64'hDEAD);

      // Port 0 write to a pending register leaves it pending.
      issue_valid = 1'b1; issue_rd = 7;
      tick();
      issue_valid = 1'b0;
      p0_valid = 1'b1; p0_rd = 7; p0_data = 32'h77;
      expect_wr(7, 32'h77);
      tick();
      p0_valid = 1'b0;
      tick();
      chk("p0_no_clear_hazard", 64'(hazard), 64'd1);
      chk("p0_no_clear_issue", 64'(issue_ready), 64'd0);
      chk("rf_read_7_p0", 64'(rf[7]), 64'h77);
      q_rs1 = 0; q_rd = 7;
      #1;
      chk("hazard_qrd", 64'(hazard), 64'd1);
      q_rd = 0; q_rs2 = 7;
      #1;
      chk("hazard_qrs2", 64'(hazard), 64'd1);
      q_rs2 = 0;
      #1;
      chk("hazard_q_zero", 64'(hazard), 64'd0);

      // rd=0 cases.
      p1_valid = 1'b1; p1_rd = 0; p1_data = 32'h99;
      #1;
      chk("p1_rd0_ready", 64'(p1_ready), 64'd1);
      tick();
      p1_valid = 1'b0;
      chk("p1_rd0_wr_en", 64'(wr_en), 64'd0);
      issue_rd = 0; issue_valid = 1'b1;
      #1;
      chk("issue_rd0_ready", 64'(issue_ready), 64'd1);
      tick();
      issue_valid = 1'b0;
      chk("issue_rd0_ready_after", 64'(issue_ready), 64'd1);

      // Back-to-back port 0 writes.
      p0_valid = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         p0_rd = REG_W'(i); p0_data = 32'h101 * i;
         expect_wr(REG_W'(i), 32'h101 * i);
         tick();
         chk("burst_wr_en", 64'(wr_en), 64'd1);
      end
      // Reset mid-burst: the registered write is dropped at once.
      p0_rd = 10; p0_data = 32'hAAA;
      tick();
      chk("burst_pre_reset_wr_en", 64'(wr_en), 64'd1);
      reset = 1'b0;
      #1;
      chk("async_reset_wr_en", 64'(wr_en), 64'd0);
      chk("async_reset_wr_rd", 64'(wr_rd), 64'd0);
      p0_valid = 1'b0;
      tick();
      reset = 1'b1; q_rs1 = 7; issue_rd = 7;
      #1;
      chk("reset_cleared_pending", 64'(hazard), 64'd0);
      chk("reset_issue_ready", 64'(issue_ready), 64'd1);
      tick();
      tick();
      chk("queue_drained", 64'(expq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
